// File: rtl/axis_window.sv
// AXI4-Stream windowing stage: multiplies each sample by a coefficient from an external synchronous RAM.
// Optional macro AXIS_WINDOW_SATURATION_EN: saturate (instead of wrap) on each width reduction.
module axis_window #(
  parameter int window_length              = 32,
  parameter int inout_width                = 16,
  parameter int inout_decimal_width        = 15,
  parameter int window_coeff_width         = 16,
  parameter int window_coeff_decimal_width = 15,
  parameter int internal_width             = 16,
  parameter int internal_decimal_width     = 15,
  parameter int memory_depth_width         = 6
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic [inout_width-1:0]        s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [inout_width-1:0]        m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [memory_depth_width-1:0] mem_addr,
  input  logic [window_coeff_width-1:0] mem_din
);

  localparam int prod_w = inout_width + window_coeff_width;
  localparam int ext_w  = prod_w + internal_width;
  localparam int shift1 = inout_decimal_width + window_coeff_decimal_width - internal_decimal_width;
  localparam int shift2 = internal_decimal_width - inout_decimal_width;
  localparam logic [memory_depth_width-1:0] last_idx = memory_depth_width'(window_length - 1);

  logic [memory_depth_width-1:0]   idx_r;
  logic [memory_depth_width-1:0]   i1_r;
  logic                            v1_r;
  logic signed [inout_width-1:0]   x1_r;
  logic                            en_s;
  logic signed [prod_w-1:0]        prod_s;
  logic signed [ext_w-1:0]         ext_s;
  logic signed [ext_w-1:0]         q_s;
  logic signed [ext_w-1:0]         o_s;
  logic [inout_width-1:0]          scaled_s;
  logic                            unused_s;

  // Reduce a sign-extended value to tw significant bits, keeping it sign-extended to ext_w.
  function automatic logic signed [ext_w-1:0] reduce_fn(input logic signed [ext_w-1:0] v, input int tw);
`ifdef AXIS_WINDOW_SATURATION_EN
    logic signed [ext_w-1:0] one_v;
    logic signed [ext_w-1:0] min_v;
    logic signed [ext_w-1:0] max_v;
    one_v = {{(ext_w-1){1'b0}}, 1'b1};
    min_v = -(one_v <<< (tw - 1));
    max_v = -min_v - one_v;
    if (v > max_v) begin
      reduce_fn = max_v;
    end else if (v < min_v) begin
      reduce_fn = min_v;
    end else begin
      reduce_fn = v;
    end
`else
    reduce_fn = (v <<< (ext_w - tw)) >>> (ext_w - tw);
`endif
  endfunction

  assign en_s          = m_axis_tready;
  assign s_axis_tready = resetn & m_axis_tready;
  // Under stall the RAM re-reads the held sample's coefficient so mem_din stays valid.
  assign mem_addr      = en_s ? idx_r : i1_r;

  // Fixed-point multiply, floor-shift and width reduction of the stage-1 sample.
  always_comb begin
    prod_s   = x1_r * $signed(mem_din);
    ext_s    = {{internal_width{prod_s[prod_w-1]}}, prod_s};
    q_s      = reduce_fn(ext_s >>> shift1, internal_width);
    o_s      = reduce_fn(q_s >>> shift2, inout_width);
    scaled_s = o_s[inout_width-1:0];
    unused_s = ^{s_axis_tlast, o_s[ext_w-1:inout_width]};
  end

  // Two-stage pipeline: capture/index stage followed by the registered output stage.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      idx_r         <= '0;
      i1_r          <= '0;
      v1_r          <= 1'b0;
      x1_r          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (en_s) begin
      if (s_axis_tvalid) begin
        x1_r  <= s_axis_tdata;
        i1_r  <= idx_r;
        v1_r  <= 1'b1;
        idx_r <= (idx_r == last_idx) ? '0 : idx_r + memory_depth_width'(1);
      end else begin
        v1_r  <= 1'b0;
      end
      if (v1_r) begin
        m_axis_tdata  <= scaled_s;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (i1_r == last_idx);
      end else begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_window.sv
// Directed bench for axis_window: vector table of single samples plus burst, stall and reset sequences.
module tb_axis_window;

  logic        aclk;
  logic        resetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [5:0]  mem_addr;
  logic [15:0] mem_din;

  logic [15:0] coef_mem [0:63];
  int checks;
  int errors;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] c;
    int                 exp;
  } vec_t;
  vec_t vt [10];

  axis_window dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Synchronous coefficient RAM with one-cycle read latency.
  always @(posedge aclk) mem_din <= coef_mem[mem_addr];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input logic [15:0] c);
    for (int k = 0; k < 64; k++) coef_mem[k] = c;
  endtask

  function automatic int exp_d(input int j, input int base);
    return (j + 1) * (((base + j) % 32) + 1);
  endfunction

  function automatic int exp_l(input int j, input int base);
    return (((base + j) % 32) == 31) ? 1 : 0;
  endfunction

  function automatic int sdat();
    return int'($signed(m_axis_tdata));
  endfunction

  // Back-to-back burst; sample i has x=64*(i+1) against coefficient 512*(idx+1), so output = (i+1)*(idx+1).
  task automatic burst(input int n, input int stall_at, input int base);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = 16'(64 * (i + 1));
      s_axis_tvalid = 1'b1;
      if (i == stall_at) begin
        m_axis_tready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
          chk("stall_sready", s_axis_tready, 0);
          chk("stall_addr", int'(mem_addr), (base + i - 1) % 32);
          chk("stall_valid", m_axis_tvalid, 1);
          chk("stall_data", sdat(), exp_d(i - 2, base));
          chk("stall_last", m_axis_tlast, exp_l(i - 2, base));
          step();
        end
        m_axis_tready = 1'b1;
        #1;
      end
      chk("burst_sready", s_axis_tready, 1);
      chk("burst_addr", int'(mem_addr), (base + i) % 32);
      step();
      if (i > 0) begin
        chk("burst_valid", m_axis_tvalid, 1);
        chk("burst_data", sdat(), exp_d(i - 1, base));
        chk("burst_last", m_axis_tlast, exp_l(i - 1, base));
      end
    end
    s_axis_tvalid = 1'b0;
    step();
    chk("burst_valid", m_axis_tvalid, 1);
    chk("burst_data", sdat(), exp_d(n - 1, base));
    chk("burst_last", m_axis_tlast, exp_l(n - 1, base));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vt[0] = '{16'sd1000, 16'sd32767, 999};
    vt[1] = '{-16'sd1000, 16'sd32767, -1000};
    vt[2] = '{16'sd16384, 16'sd16384, 8192};
`ifdef AXIS_WINDOW_SATURATION_EN
    vt[3] = '{-16'sd32768, -16'sd32768, 32767};
`else
    vt[3] = '{-16'sd32768, -16'sd32768, -32768};
`endif
    vt[4] = '{16'sd32767, 16'sd32767, 32766};
    vt[5] = '{-16'sd16384, 16'sd16384, -8192};
    vt[6] = '{16'sd1, -16'sd1, -1};
    vt[7] = '{16'sd100, -16'sd200, -1};
    vt[8] = '{16'sd3, 16'sd10923, 1};
    vt[9] = '{16'sd0, 16'sd12345, 0};

    resetn        = 1'b0;
    s_axis_tdata  = 16'd0;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    fill(16'd0);

    #50;
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_last", m_axis_tlast, 0);
    chk("rst_data", sdat(), 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_addr", int'(mem_addr), 0);
    #50;
    resetn = 1'b1;
    step();

    // Isolated samples from the vector table, indices 0..9.
    for (int v = 0; v < 10; v++) begin
      fill(vt[v].c);
      chk("vec_addr", int'(mem_addr), v);
      s_axis_tdata  = vt[v].x;
      s_axis_tvalid = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      step();
      chk("vec_valid", m_axis_tvalid, 1);
      chk("vec_data", sdat(), vt[v].exp);
      chk("vec_last", m_axis_tlast, 0);
      step();
      chk("vec_idle", m_axis_tvalid, 0);
    end

    // Spaced pulses continue the window through index 31 and wrap to 0.
    fill(16'd32767);
    for (int k = 10; k <= 32; k++) begin
      chk("sp_addr", int'(mem_addr), k % 32);
      s_axis_tdata  = 16'd1000;
      s_axis_tvalid = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      step();
      chk("sp_data", sdat(), 999);
      chk("sp_last", m_axis_tlast, (k % 32 == 31) ? 1 : 0);
      step();
      chk("sp_idle", m_axis_tvalid, 0);
      step();
    end

    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'(512 * (k + 1));
    burst(40, 20, 0);

    // Mid-window reset with one sample on the output and one in flight.
    s_axis_tdata  = 16'd320;
    s_axis_tvalid = 1'b1;
    chk("mid_addr", int'(mem_addr), 8);
    step();
    s_axis_tdata  = 16'd384;
    step();
    s_axis_tvalid = 1'b0;
    chk("mid_valid", m_axis_tvalid, 1);
    chk("mid_data", sdat(), 45);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", m_axis_tvalid, 0);
    chk("arst_data", sdat(), 0);
    chk("arst_last", m_axis_tlast, 0);
    chk("arst_sready", s_axis_tready, 0);
    chk("arst_addr", int'(mem_addr), 0);
    #2;
    resetn = 1'b1;
    step();
    chk("flush_valid", m_axis_tvalid, 0);
    step();
    chk("flush_valid", m_axis_tvalid, 0);
    burst(33, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_window.md
Name: axis_window

Overview:
- AXI4-Stream sample-windowing stage placed in front of an FFT core, for example the 16-bit xfft.
- Multiplies each incoming sample by a window coefficient read from an external synchronous coefficient memory, indexed by the sample position within the window.
- Produces a windowed stream with tlast generated on the last sample of every window.
- No decimation and no reordering.

Parameters:
- window_length, 32: samples per window; index runs 0..window_length-1 and must be ≤ 2^memory_depth_width.
- inout_width, 16: width of s_axis_tdata and m_axis_tdata, signed two's complement.
- inout_decimal_width, 15: fractional bits of the input and output samples.
- window_coeff_width, 16: width of mem_din, signed.
- window_coeff_decimal_width, 15: fractional bits of the coefficient.
- internal_width, 16: width of the scaled product before output alignment.
- internal_decimal_width, 15: fractional bits of the internal product; must be ≥ inout_decimal_width.
- memory_depth_width, 6: width of mem_addr.

Ports:
- aclk, in, 1: clock; all logic on the rising edge.
- resetn, in, 1: asynchronous active-low reset.
- s_axis_tdata, in, inout_width: input sample.
- s_axis_tlast, in, 1: ignored.
- s_axis_tvalid, in, 1: input sample valid.
- s_axis_tready, out, 1: equals m_axis_tready; forced 0 while resetn=0.
- m_axis_tdata, out, inout_width: windowed sample.
- m_axis_tlast, out, 1: high on the sample with window index window_length-1.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: downstream ready.
- mem_addr, out, memory_depth_width: coefficient memory address.
- mem_din, in, window_coeff_width: coefficient data; one-cycle synchronous read latency.

Behaviour:
- Reset, applied immediately and asynchronously:
  - index counter idx=0, stage-1 valid v1=0, stage-1 index i1=0;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Reset mid-window discards in-flight data; the next accepted sample is index 0.
- Pipeline enable: en = m_axis_tready. Accept condition = s_axis_tvalid && en.
- mem_addr = en ? idx : i1 (combinational).
  - Under stall the memory keeps re-reading the coefficient of the sample held in stage 1, so mem_din stays stable.
- On accept (edge A):
  - x1<=s_axis_tdata, i1<=idx, v1<=1;
  - idx<=idx+1, wrapping to 0 after window_length-1.
- On an en edge without accept: v1<=0.
- Output stage, on an en edge with v1=1:
  - m_axis_tdata<=scale(x1*mem_din), m_axis_tvalid<=1, m_axis_tlast<=(i1==window_length-1).
- On an en edge with v1=0: m_axis_tvalid<=0, m_axis_tlast<=0.
- While en=0: all stage registers, outputs and idx hold.
- Latency: a sample accepted at edge A appears on m_axis_* after edge A+1, i.e. 2 clocks. Throughput is 1 sample per clock when m_axis_tready=1.
- Arithmetic, scale():
  - p = signed x1 × signed mem_din, full precision, inout_width+window_coeff_width bits.
  - q = p >>> (inout_decimal_width + window_coeff_decimal_width − internal_decimal_width), arithmetic shift (floor), reduced to internal_width bits.
  - out = q >>> (internal_decimal_width − inout_decimal_width), reduced to inout_width bits.
  - Reduction is two's complement wrap, i.e. low bits kept, unless SATURATION_EN is defined.
- Simultaneous accept and output in the same edge is normal pipelined operation.
- idx counts accepted samples only; gaps in s_axis_tvalid do not advance it.

Optional Feature:
- Macro: AXIS_WINDOW_SATURATION_EN.
- Defined: each width reduction (to internal_width, then to inout_width) saturates to the signed max/min of the target width.
- Undefined: plain truncation of the upper bits (wrap).

Test Plan:
- Setup: resetn released at 100 ns; s_axis_tdata=1000, mem_din=32767, m_axis_tready=1; one-cycle tvalid pulse every 10 µs.
  - Each output = 999 (32767000>>15), 2 clocks after accept.
  - mem_addr steps 0..31 then wraps to 0.
  - m_axis_tlast high on every 32nd output only.
- Input −1000, coeff 32767 -> output −1000 (floor); input 16384, coeff 16384 -> 8192.
- Back-to-back tvalid for 40 cycles, tready=1 -> 40 consecutive outputs; tlast on outputs 32 and 40+... pattern continuing (index 31); mem_addr increments every cycle.
- Drop m_axis_tready for 5 cycles mid-stream:
  - s_axis_tready=0 during the stall;
  - m_axis_tdata, m_axis_tvalid, m_axis_tlast and mem_addr held;
  - no sample lost or duplicated after release.
- Assert resetn=0 after 10 samples of a window -> outputs clear immediately; after release, first sample uses mem_addr 0 and tlast comes 32 samples later.
- x=−32768, coeff=−32768 -> 32767 with AXIS_WINDOW_SATURATION_EN, −32768 without.
